// File: rtl/gray_step_monitor.sv
// Consumer of the 3-bit Gray counter stage: converts the code to binary, counts forward
// steps and 7->0 laps, and latches a sticky fault on illegal transitions or a stray Overflow rise.
module gray_step_monitor #(
    parameter int STEP_W = 16,
    parameter int LAP_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Clear,
    input  logic [2:0]        Gray,
    input  logic              Overflow,
    output logic [2:0]        Bin,
    output logic [STEP_W-1:0] Steps,
    output logic [LAP_W-1:0]  Laps,
    output logic              Valid,
    output logic              Error,
    output logic [1:0]        ErrCode,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] last_code;
    logic       last_ovf;

    logic [2:0] new_bin;
    logic [2:0] diff;
    logic       same, fwd, wrap, ovf_rise, multi, code_err, ovf_err;
    logic [1:0] err_code_nxt;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Bin always holds the binary of last_code once a baseline exists, so it serves as the reference.
    always_comb begin
        new_bin      = gray2bin(Gray);
        diff         = Gray ^ last_code;
        same         = (diff == 3'b000);
        fwd          = !same && (new_bin == Bin + 3'd1);
        wrap         = fwd && (Bin == 3'd7);
        ovf_rise     = Overflow && !last_ovf;
        multi        = ((diff & (diff - 3'd1)) != 3'b000);
        code_err     = !same && !fwd;
        ovf_err      = ovf_rise && !wrap;
        err_code_nxt = code_err ? (multi ? 2'b01 : 2'b10) : 2'b11;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = TRACK;
            TRACK:   if (code_err || ovf_err) state_nxt = FAULT;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = INIT;
        endcase
        if (Clear) state_nxt = INIT;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= INIT;
        else          state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_code <= 3'b000;
            last_ovf  <= 1'b0;
            Bin       <= 3'b000;
            Steps     <= '0;
            Laps      <= '0;
            Error     <= 1'b0;
            ErrCode   <= 2'b00;
        end else if (Clear) begin
            last_code <= 3'b000;
            last_ovf  <= 1'b0;
            Bin       <= 3'b000;
            Steps     <= '0;
            Laps      <= '0;
            Error     <= 1'b0;
            ErrCode   <= 2'b00;
        end else begin
            case (state)
                INIT: begin
                    last_code <= Gray;
                    last_ovf  <= Overflow;
                    Bin       <= new_bin;
                end
                TRACK: begin
                    last_ovf <= Overflow;
                    if (fwd) begin
                        last_code <= Gray;
                        Bin       <= new_bin;
                        Steps     <= Steps + STEP_W'(1);
                        if (wrap && (Laps != {LAP_W{1'b1}})) Laps <= Laps + LAP_W'(1);
                    end
                    if (code_err || ovf_err) begin
                        Error   <= 1'b1;
                        ErrCode <= err_code_nxt;
                    end
                end
                default: last_ovf <= Overflow;
            endcase
        end
    end

    assign Valid     = (state != INIT);
    assign dbg_state = state;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: directed scenarios plus random traffic, scored against a
// position/count model; a narrow-width second instance exercises Steps wrap and Laps saturation.
module tb_gray_step_monitor;

    localparam int EXP_W = 37;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clear, ovf;
    logic [2:0] gray;

    logic [2:0]  a_bin,   b_bin;
    logic [15:0] a_steps;
    logic [3:0]  b_steps;
    logic [7:0]  a_laps;
    logic [1:0]  b_laps;
    logic        a_valid, b_valid, a_error, b_error;
    logic [1:0]  a_ec, b_ec, a_dbg, b_dbg;

    gray_step_monitor #(.STEP_W(16), .LAP_W(8)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .Clear(clear), .Gray(gray), .Overflow(ovf),
        .Bin(a_bin), .Steps(a_steps), .Laps(a_laps), .Valid(a_valid),
        .Error(a_error), .ErrCode(a_ec), .dbg_state(a_dbg));

    gray_step_monitor #(.STEP_W(4), .LAP_W(2)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Clear(clear), .Gray(gray), .Overflow(ovf),
        .Bin(b_bin), .Steps(b_steps), .Laps(b_laps), .Valid(b_valid),
        .Error(b_error), .ErrCode(b_ec), .dbg_state(b_dbg));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               due_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: upstream position in the legal sequence, plus plain integer totals.
    logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    int         m_pos, m_steps, m_laps;
    bit         m_base, m_fault, m_ovf;
    logic [2:0] m_last;
    logic [1:0] m_ec;

    function automatic int idx_of(input logic [2:0] g);
        for (int i = 0; i < 8; i++) if (seq[i] == g) return i;
        return 0;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_steps = 0; m_laps = 0;
        m_base = 0; m_fault = 0; m_ovf = 0; m_last = 3'b000; m_ec = 2'b00;
    endtask

    task automatic model_update(input bit c, input logic [2:0] g, input bit o);
        bit rise, wrap;
        int ni;
        rise = o && !m_ovf;
        wrap = 0;
        ni   = idx_of(g);
        if (c) model_reset();
        else if (!m_base) begin
            m_base = 1; m_last = g; m_pos = ni; m_ovf = o;
        end else if (m_fault) m_ovf = o;
        else begin
            if (g != m_last) begin
                if (ni == (m_pos + 1) % 8) begin
                    wrap = (m_pos == 7);
                    m_pos = ni; m_last = g; m_steps++;
                    if (wrap) m_laps++;
                end else begin
                    m_fault = 1;
                    m_ec = ($countones(g ^ m_last) > 1) ? 2'b01 : 2'b10;
                end
            end
            if (rise && !wrap && !m_fault) begin
                m_fault = 1; m_ec = 2'b11;
            end
            m_ovf = o;
        end
    endtask

    function automatic logic [EXP_W-1:0] model_expect();
        logic [15:0] s16;
        logic [7:0]  l8;
        logic [3:0]  s4;
        logic [1:0]  l2;
        s16 = 16'(m_steps % 65536);
        l8  = 8'(min_i(m_laps, 255));
        s4  = 4'(m_steps % 16);
        l2  = 2'(min_i(m_laps, 3));
        return {3'(m_pos), s16, l8, m_base, m_fault, m_ec, s4, l2};
    endfunction

    // Driver: inputs change 1ns after a rising edge; the result is due after the next edge.
    task automatic drive(input bit c, input logic [2:0] g, input bit o);
        @(posedge clk);
        #1;
        clear = c; gray = g; ovf = o;
        model_update(c, g, o);
        exp_q.push_back(model_expect());
        due_q.push_back(cyc + 1);
    endtask

    // Monitor: every DUT output is registered, so compare on the falling edge.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e, a;
        if (rst_n && exp_q.size() > 0 && cyc >= due_q[0]) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            a = {a_bin, a_steps, a_laps, a_valid, a_error, a_ec, b_steps, b_laps};
            n_cmp++;
            if (a !== e || b_bin !== e[36:34] || b_valid !== e[9] || b_error !== e[8] || b_ec !== e[7:6]) begin
                n_fail++;
                $display("FAIL scoreboard cyc=%0d got bin=%0d steps=%0d laps=%0d v=%0b e=%0b ec=%0d s4=%0d l2=%0d b_bin=%0d required bin=%0d steps=%0d laps=%0d v=%0b e=%0b ec=%0d s4=%0d l2=%0d",
                         cyc, a[36:34], a[33:18], a[17:10], a[9], a[8], a[7:6], a[5:2], a[1:0], b_bin,
                         e[36:34], e[33:18], e[17:10], e[9], e[8], e[7:6], e[5:2], e[1:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
            exp_q.delete(); due_q.delete();
        end
    endtask

    task automatic reset_pulse(input logic [2:0] g);
        rst_n = 1'b0; clear = 1'b0; gray = g; ovf = 1'b0;
        model_reset();
        #12;
        chk("reset_bin", a_bin, 0);   chk("reset_steps", a_steps, 0);
        chk("reset_laps", a_laps, 0); chk("reset_valid", a_valid, 0);
        chk("reset_error", a_error, 0); chk("reset_errcode", a_ec, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r, nxt;
        reset_pulse(3'b011);

        // T1: baseline 011 converts to 2
        drive(0, 3'b011, 0);
        wait_drain();
        chk("t1_bin", a_bin, 2); chk("t1_valid", a_valid, 1); chk("t1_steps", a_steps, 0);

        // T2: nine legal steps from 000 with Overflow rising on the wrap
        drive(1, 3'b000, 0);
        drive(0, 3'b000, 0);
        for (int i = 1; i <= 9; i++) drive(0, seq[i % 8], (i >= 8));
        wait_drain();
        chk("t2_steps", a_steps, 9); chk("t2_laps", a_laps, 1);
        chk("t2_bin", a_bin, 1);     chk("t2_error", a_error, 0);

        // T3: two-bit change, then a legal-looking code that must not count
        drive(1, 3'b000, 0);
        drive(0, 3'b001, 0);
        drive(0, 3'b010, 0);
        drive(0, 3'b011, 0);
        wait_drain();
        chk("t3_error", a_error, 1); chk("t3_errcode", a_ec, 1);
        chk("t3_bin", a_bin, 1);     chk("t3_steps", a_steps, 0);

        // T4: backward step, then Overflow rise with code held
        drive(1, 3'b000, 0);
        drive(0, 3'b011, 0);
        drive(0, 3'b001, 0);
        wait_drain();
        chk("t4_backward_errcode", a_ec, 2);
        drive(1, 3'b000, 0);
        drive(0, 3'b010, 0);
        drive(0, 3'b010, 1);
        wait_drain();
        chk("t4_ovf_errcode", a_ec, 3); chk("t4_ovf_error", a_error, 1);

        // T5: Clear with an illegal code in the same cycle, then a fresh baseline
        drive(1, 3'b111, 0);
        wait_drain();
        chk("t5_error", a_error, 0); chk("t5_valid", a_valid, 0);
        drive(0, 3'b110, 0);
        wait_drain();
        chk("t5_bin", a_bin, 4); chk("t5_valid_again", a_valid, 1);

        // T6: narrow instance wraps Steps and saturates Laps
        drive(1, 3'b000, 0);
        drive(0, 3'b000, 0);
        for (int i = 1; i <= 17; i++) drive(0, seq[i % 8], 0);
        wait_drain();
        chk("t6_steps4", b_steps, 1); chk("t6_steps16", a_steps, 17);
        for (int i = 18; i <= 40; i++) drive(0, seq[i % 8], 0);
        wait_drain();
        chk("t6_laps2", b_laps, 3); chk("t6_laps8", a_laps, 5);

        // Asynchronous reset away from any clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_steps", a_steps, 0); chk("async_laps", a_laps, 0); chk("async_valid", a_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic: mostly legal steps, holds, stray codes, clears, Overflow rise on wraps
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            if (ovf && $urandom_range(0, 19) == 0) ovf = 1'b0;
            if ((m_fault && r < 30) || r < 4) drive(1, 3'($urandom_range(0, 7)), ovf);
            else if (r < 70) begin
                nxt = (m_pos + 1) % 8;
                drive(0, seq[nxt], ovf || (nxt == 0 && m_base && $urandom_range(0, 1) == 1));
            end else if (r < 85) drive(0, m_last, ovf);
            else drive(0, 3'($urandom_range(0, 7)), ovf);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
